// File: rtl/word_serializer.sv
// Word serializer: captures an 8-bit word on a load request and sends it
// as an 11-bit frame on a single line. The frame is a start bit, eight data
// bits LSB first, an even-parity bit and a stop bit. Each bit is held for
// DIV clock cycles. Load requests that arrive while a frame is on the line
// are not queued; they are counted in a saturating 8-bit drop counter.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line held at 1, waiting for a load request
// START  | start bit (0) on the line for DIV cycles
// DATA   | data bit shift_q[0] on the line; idx_q counts bits 0..7
// PARITY | even-parity bit (XOR of the captured word) on the line
// STOP   | stop bit (1) on the line; the frame ends after the last cycle
module word_serializer #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] __in0,
  input  logic       __in1,
  output logic       __out0,
  output logic       __out1,
  output logic [7:0] __out2
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Last divider value of a bit period; the bit ends when the divider reaches it.
  localparam logic [7:0] DIV_TC = 8'(DIV - 1);

  // The initial values match the reset values, so the block idles correctly
  // from time zero before the first reset arrives.
  state_t     state_q = IDLE;
  state_t     state_d;
  logic [7:0] div_q   = 8'h00;
  logic [7:0] div_d;
  logic [2:0] idx_q   = 3'd0;
  logic [2:0] idx_d;
  logic [7:0] shift_q = 8'h00;
  logic [7:0] shift_d;
  logic       par_q   = 1'b0;
  logic       par_d;
  logic [7:0] drop_q  = 8'h00;
  logic [7:0] drop_d;

  logic       busy;
  logic       bit_done;

  assign busy     = (state_q != IDLE);
  assign bit_done = (div_q == DIV_TC);

  // Next-state logic: bit timing, frame sequencing and word capture.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;

    case (state_q)
      IDLE: begin
        div_d = 8'h00;
        idx_d = 3'd0;
        if (__in1) begin
          // The word is sampled only here. Later changes on __in0 do not
          // reach the frame, and the parity is fixed at this point because
          // the shift register is consumed while the frame is sent.
          shift_d = __in0;
          par_d   = ^__in0;
          state_d = START;
        end
      end

      START: begin
        if (bit_done) begin
          div_d   = 8'h00;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      DATA: begin
        if (bit_done) begin
          div_d   = 8'h00;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      PARITY: begin
        if (bit_done) begin
          div_d   = 8'h00;
          state_d = STOP;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      STOP: begin
        if (bit_done) begin
          div_d   = 8'h00;
          state_d = IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        div_d   = 8'h00;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Drop counter: one count per busy cycle with a request, saturating at FF.
  // A request in the last STOP cycle is dropped because busy is still 1.
  always_comb begin
    drop_d = drop_q;
    if (__in1 && busy && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Line driver: decoded from the registered state, so the start bit appears
  // in the cycle after the capturing edge.
  always_comb begin
    __out0 = 1'b1;
    case (state_q)
      IDLE:    __out0 = 1'b1;
      START:   __out0 = 1'b0;
      DATA:    __out0 = shift_q[0];
      PARITY:  __out0 = par_q;
      STOP:    __out0 = 1'b1;
      default: __out0 = 1'b1;
    endcase
  end

  assign __out1 = busy;
  assign __out2 = drop_q;

  // State register. Reset wins over a request in the same cycle and abandons
  // any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= 8'h00;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      drop_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      drop_q  <= drop_d;
    end
  end

endmodule
